// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 Set-2 byte codes, decoder state type and byte classifiers
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    // Keyboard status/response bytes that never represent a key
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_OVF_LO   = 8'h00;
    localparam logic [7:0] PS2_OVF_HI   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_e;

    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_BAT_FAIL) ||
               (b == PS2_RESEND) || (b == PS2_OVF_LO) || (b == PS2_OVF_HI);
    endfunction

    function automatic logic is_shift(input logic [7:0] b);
        return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_typematic_filter.sv
// rtl/ps2_typematic_filter.sv - held-key register that suppresses auto-repeat makes
// Built only when PS2_TYPEMATIC_FILTER_EN is defined.
`ifdef PS2_TYPEMATIC_FILTER_EN
module ps2_typematic_filter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       make,
    input  logic       brk,
    input  logic       clear,
    input  logic       ext,
    input  logic [7:0] code,
    output logic       pass
);

    logic       held_vld;
    logic       held_ext;
    logic [7:0] held_code;
    logic       match;

    assign match = held_vld && (held_ext == ext) && (held_code == code);
    assign pass  = !match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_vld  <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= 8'h00;
        end else if (clear) begin
            held_vld <= 1'b0;
        end else if (make) begin
            held_vld  <= 1'b1;
            held_ext  <= ext;
            held_code <= code;
        end else if (brk && match) begin
            held_vld <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 Set-2 prefix stripper and shift tracker, one strobe per key press
// Optional auto-repeat suppression with PS2_TYPEMATIC_FILTER_EN.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_shift,
    output logic       key_valid,
    output logic       shift_held
);

    localparam logic [7:0] SKIP_LOAD = 8'(PAUSE_SKIP);

    ps2_state_e state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       lshift, rshift;
    logic       make_evt, brk_evt, evt_ext;
    logic       byte_shift, key_evt, pass;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        make_evt   = 1'b0;
        brk_evt    = 1'b0;
        evt_ext    = 1'b0;
        if (rx_err) begin
            state_next = ST_IDLE;
            cnt_next   = 8'h00;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == PS2_BRK) begin
                        state_next = ST_BRK;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_next = ST_SKIP;
                        cnt_next   = SKIP_LOAD;
                    end else begin
                        make_evt = !is_discard(rx_data);
                    end
                end
                ST_EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if ((rx_data != PS2_EXT) && (rx_data != PS2_PAUSE)) begin
                        make_evt   = 1'b1;
                        evt_ext    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_evt    = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    brk_evt    = 1'b1;
                    evt_ext    = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_SKIP: begin
                    // A stray zero count must not strand the FSM in SKIP
                    if (cnt <= 8'd1) begin
                        cnt_next   = 8'h00;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'h00;
                end
            endcase
        end
    end

    assign byte_shift = is_shift(rx_data);
    assign key_evt    = make_evt && !byte_shift && pass;
    assign shift_held = lshift | rshift;

`ifdef PS2_TYPEMATIC_FILTER_EN
    ps2_typematic_filter u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .make  (make_evt && !byte_shift),
        .brk   (brk_evt),
        .clear (rx_err),
        .ext   (evt_ext),
        .code  (rx_data),
        .pass  (pass)
    );
`else
    assign pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'h00;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_shift <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            key_valid <= key_evt;
            if (key_evt) begin
                key_code  <= rx_data;
                key_ext   <= evt_ext;
                key_shift <= lshift | rshift;
            end
            // Extended 12/59 are Print Screen fakes and never touch the shift flags
            if ((make_evt || brk_evt) && !evt_ext) begin
                if (rx_data == PS2_LSHIFT) lshift <= make_evt;
                if (rx_data == PS2_RSHIFT) rshift <= make_evt;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - directed vector bench for ps2_scan_decoder
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_shift;
    logic       key_valid;
    logic       shift_held;

    int checks = 0;
    int failures = 0;

    ps2_scan_decoder #(.PAUSE_SKIP(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_shift  (key_shift),
        .key_valid  (key_valid),
        .shift_held (shift_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       e;
        logic       kv;
        logic [7:0] code;
        logic       ext;
        logic       ks;
        logic       sh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic e,
                                input logic kv, input logic [7:0] code,
                                input logic ext, input logic ks, input logic sh);
        vec_t r;
        r.d = d; r.v = v; r.e = e; r.kv = kv;
        r.code = code; r.ext = ext; r.ks = ks; r.sh = sh;
        return r;
    endfunction

    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        rx_data  = d;
        rx_valid = v;
        rx_err   = e;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [11:0] got, want;
    int          kv_cnt;
    logic [7:0]  last_code;

    initial begin
        // press/release, shifted key, extended keys
        vecs.push_back(mk(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0));
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h1C, 0, 0, 0));
        vecs.push_back(mk(8'h1C, 1, 0, 0, 8'h1C, 0, 0, 0));
        vecs.push_back(mk(8'h12, 1, 0, 0, 8'h1C, 0, 0, 1));
        vecs.push_back(mk(8'h16, 1, 0, 1, 8'h16, 0, 1, 1));
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h16, 0, 1, 1));
        vecs.push_back(mk(8'h16, 1, 0, 0, 8'h16, 0, 1, 1));
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h16, 0, 1, 1));
        vecs.push_back(mk(8'h12, 1, 0, 0, 8'h16, 0, 1, 0));
        vecs.push_back(mk(8'hE0, 1, 0, 0, 8'h16, 0, 1, 0));
        vecs.push_back(mk(8'h75, 1, 0, 1, 8'h75, 1, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h75, 1, 0, 0));
        vecs.push_back(mk(8'hE0, 1, 0, 0, 8'h75, 1, 0, 0));
        vecs.push_back(mk(8'h12, 1, 0, 0, 8'h75, 1, 0, 0));
        vecs.push_back(mk(8'hE0, 1, 0, 0, 8'h75, 1, 0, 0));
        vecs.push_back(mk(8'h7C, 1, 0, 1, 8'h7C, 1, 0, 0));
        // error recovery: break prefix dropped, next byte is a make
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h7C, 1, 0, 0));
        vecs.push_back(mk(8'h00, 0, 1, 0, 8'h7C, 1, 0, 0));
        vecs.push_back(mk(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0));
        // error and byte in the same cycle: byte lost
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h1C, 0, 0, 0));
        vecs.push_back(mk(8'h2A, 1, 1, 0, 8'h1C, 0, 0, 0));
        vecs.push_back(mk(8'h2A, 1, 0, 1, 8'h2A, 0, 0, 0));
        // status bytes discarded
        vecs.push_back(mk(8'hAA, 1, 0, 0, 8'h2A, 0, 0, 0));
        vecs.push_back(mk(8'hFA, 1, 0, 0, 8'h2A, 0, 0, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 0, 8'h2A, 0, 0, 0));
        // right shift, fake extended shift break ignored
        vecs.push_back(mk(8'h59, 1, 0, 0, 8'h2A, 0, 0, 1));
        vecs.push_back(mk(8'h1B, 1, 0, 1, 8'h1B, 0, 1, 1));
        vecs.push_back(mk(8'hE0, 1, 0, 0, 8'h1B, 0, 1, 1));
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h1B, 0, 1, 1));
        vecs.push_back(mk(8'h59, 1, 0, 0, 8'h1B, 0, 1, 1));
        vecs.push_back(mk(8'hF0, 1, 0, 0, 8'h1B, 0, 1, 1));
        vecs.push_back(mk(8'h59, 1, 0, 0, 8'h1B, 0, 1, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {20'h0, key_valid, key_code, key_ext, key_shift, shift_held}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].e);
            got  = {key_valid, key_code, key_ext, key_shift, shift_held};
            want = {vecs[i].kv, vecs[i].code, vecs[i].ext, vecs[i].ks, vecs[i].sh};
            check($sformatf("vec%0d", i), {20'h0, got}, {20'h0, want});
        end

        // Pause sequence then a make: only the make is reported
        kv_cnt = 0;
        last_code = 8'h00;
        foreach (vecs[i]) begin end
        begin
            logic [7:0] seq [9];
            seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
            for (int i = 0; i < 9; i++) begin
                drive(seq[i], 1'b1, 1'b0);
                if (key_valid) begin
                    kv_cnt++;
                    last_code = key_code;
                end
            end
        end
        check("pause_kv_count", kv_cnt, 1);
        check("pause_code", {24'h0, last_code}, 32'h1C);

        // reset mid-sequence drops the E0 prefix
        drive(8'hE0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("async_reset", {31'h0, key_valid}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // typematic repeat
        kv_cnt = 0;
        begin
            logic [7:0] tseq [6];
            tseq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
            for (int i = 0; i < 6; i++) begin
                drive(tseq[i], 1'b1, 1'b0);
                if (i == 0)
                    check("post_reset_not_ext", {23'h0, key_valid, key_code, key_ext},
                          {23'h0, 1'b1, 8'h1C, 1'b0});
                if (key_valid) kv_cnt++;
            end
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typematic_kv_count", kv_cnt, 2);
`else
        check("typematic_kv_count", kv_cnt, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
